regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (regwrite, add_rd, write_data) between two writeback requesters: port 0 (ALU result) and port 1 (load/memory result).
- Arbitrates round-robin and registers the winning write into the port.
- Keeps a pending-write scoreboard over all architectural registers.
- Issue logic queries the scoreboard for RAW hazards on rs1/rs2.
- Sits between the execute/memory stages and the register file.

Parameters:
ADD_WIDTH, 5, register address width; NREG = 2**ADD_WIDTH registers
DATA_WIDTH, 32, register data width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
wb0_valid  in  1  ALU writeback request
wb0_rd  in  ADD_WIDTH  ALU destination register
wb0_data  in  DATA_WIDTH  ALU result
wb0_ready  out  1  ALU request accepted this cycle
wb1_valid  in  1  load writeback request
wb1_rd  in  ADD_WIDTH  load destination register
wb1_data  in  DATA_WIDTH  load result
wb1_ready  out  1  load request accepted this cycle
sb_set  in  1  issue marks a destination as pending
sb_set_rd  in  ADD_WIDTH  destination being issued
chk_rs1  in  ADD_WIDTH  source 1 to check
chk_rs2  in  ADD_WIDTH  source 2 to check
hazard  out  1  busy[chk_rs1] | busy[chk_rs2], combinational
busy  out  NREG  scoreboard vector
regwrite  out  1  register-file write enable, registered
add_rd  out  ADD_WIDTH  register-file write address, registered
write_data  out  DATA_WIDTH  register-file write data, registered

Behaviour:
Reset:
- Synchronous, active-high; wins over all other inputs in the same cycle.
- Reset values: regwrite=0, add_rd=0, write_data=0, busy=0, rr_last=1 (so port 0 wins the first contention).
- Reset mid-operation discards any accepted but uncommitted write. regwrite=0 the next cycle.

Handshake:
- A transfer occurs when wbN_valid & wbN_ready.
- wbN_ready is combinational from the valids and rr_last. The write port never back-pressures.
- Only one valid: that port is granted.
- Both valid: grant the port that is not rr_last. rr_last updates to the granted port only on a contested grant.
- Exactly one ready is high per cycle, at most. Both readys are 0 when neither port is valid.
- A requester whose ready is 0 holds valid, rd and data stable until it is accepted.

Write path, latency 1:
- Transfer in cycle t gives regwrite=1 in cycle t+1, with add_rd and write_data equal to the granted rd and data.
- The register file captures the value at the end of cycle t+1.
- No transfer in cycle t gives regwrite=0 in t+1. add_rd and write_data hold their previous values.
- rd == 0: the handshake completes, but regwrite=0 in t+1 (x0 is never written).

Scoreboard:
- busy[r] is set at the edge when sb_set=1 and sb_set_rd=r, r != 0.
- busy[r] is cleared at the edge ending a cycle where regwrite=1 and add_rd=r, i.e. the same edge the register file is written.
- Set and clear of the same r in the same cycle: set wins, because a newer producer has been issued.
- busy[0] is constant 0.
- A set of a register that is already busy keeps it busy. Producer counting is not required: issue never has two in-flight writers to one rd.
- hazard is combinational and reflects busy as of the start of the current cycle. No bypass of the current cycle's clear.

Decomposition:
- Shared package regfile_pkg:
  - ADD_WIDTH and DATA_WIDTH defaults.
  - NREG.
  - typedef wb_req_t {valid, rd, data}.
  - Port-index constants WB_ALU=0 and WB_LOAD=1.
- One natural sub-module, wb_rr_arb2: the 2-way round-robin grant with the rr_last register.
- The write register and scoreboard stay in the top module.

Test Plan:
1. Reset, then wb0 valid with rd=5, data=32'h00000034, in cycle 1 → wb0_ready=1 in cycle 1; cycle 2 has regwrite=1, add_rd=5, write_data=32'h00000034.
2. Both valid in cycles 1–3:
   - Inputs: wb0 rd=6, data=32'h2; wb1 rd=7, data=32'h1. Each requester deasserts valid after its own acceptance.
   - Cycle 1 grants wb0, cycle 2 grants wb1.
   - regwrite in cycles 2 and 3 with add_rd 6 then 7; no data loss.
3. Scoreboard:
   - Stimulus: sb_set rd=9 in cycle 0; chk_rs1=9 in cycle 1; wb1 rd=9 accepted in cycle 2.
   - hazard=1 in cycles 1–3; busy[9]=0 and hazard=0 from cycle 4.
4. x0 write and set:
   - wb0 rd=0, data=32'hFFFFFFFF → wb0_ready=1 but regwrite=0 next cycle.
   - sb_set rd=0 → busy stays 0.
5. Same-cycle set and clear: regwrite add_rd=11 commits while sb_set rd=11 → busy[11]=1 after the edge.
6. rst asserted in the cycle after a transfer → regwrite=0, busy=0 next cycle; a subsequent contention grants wb0 first.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Two writeback ports share one register-file write port.
package regfile_pkg;

  localparam int ADD_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NREG       = 2 ** ADD_WIDTH;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;

  typedef struct packed {
    logic                  valid;
    logic [ADD_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channel: valid/rd/data from a requester,
// ready back from the arbiter.
interface regfile_wb_if #(
  parameter int ADD_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  valid;
  logic [ADD_WIDTH-1:0]  rd;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (
    output valid,
    output rd,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  rd,
    input  data,
    output ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin grant; rr_last remembers the winner of the
// most recent contested cycle only.
module wb_rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      (&req): begin
        gnt[WB_ALU]  = rr_last;
        gnt[WB_LOAD] = ~rr_last;
      end
      default: gnt = req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (&req) begin
      rr_last <= gnt[WB_LOAD];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: registers the winning write into the register
// file and tracks pending destinations for RAW hazard checks.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADD_WIDTH  = regfile_pkg::ADD_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wb_if.slave             wb0,
  regfile_wb_if.slave             wb1,
  input  logic                    sb_set,
  input  logic [ADD_WIDTH-1:0]    sb_set_rd,
  input  logic [ADD_WIDTH-1:0]    chk_rs1,
  input  logic [ADD_WIDTH-1:0]    chk_rs2,
  output logic                    hazard,
  output logic [2**ADD_WIDTH-1:0] busy,
  output logic                    regwrite,
  output logic [ADD_WIDTH-1:0]    add_rd,
  output logic [DATA_WIDTH-1:0]   write_data
);

  localparam int NR = 2 ** ADD_WIDTH;

  logic [1:0]            gnt;
  logic                  xfer;
  logic [ADD_WIDTH-1:0]  win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  do_write;
  logic [NR-1:0]         busy_q;
  logic [NR-1:0]         busy_n;
  logic [NR-1:0]         set_v;
  logic [NR-1:0]         clr_v;

  wb_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb1.valid, wb0.valid}),
    .gnt (gnt)
  );

  assign wb0.ready = gnt[WB_ALU];
  assign wb1.ready = gnt[WB_LOAD];
  assign xfer      = |gnt;

  assign win_rd   = gnt[WB_LOAD] ? wb1.rd : wb0.rd;
  assign win_data = gnt[WB_LOAD] ? wb1.data : wb0.data;
  // x0 writes complete the handshake but never reach the file
  assign do_write = xfer && (win_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite   <= 1'b0;
      add_rd     <= '0;
      write_data <= '0;
    end else begin
      regwrite <= do_write;
      if (do_write) begin
        add_rd     <= win_rd;
        write_data <= win_data;
      end
    end
  end

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (sb_set) set_v[sb_set_rd] = 1'b1;
    if (regwrite) clr_v[add_rd] = 1'b1;
    // a newer producer issued this cycle outranks the retiring one
    busy_n    = (busy_q & ~clr_v) | set_v;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_n;
    end
  end

  assign busy   = busy_q;
  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with an expected-write queue
// checked against every committed register-file write.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  sb_set;
  logic [ADD_WIDTH-1:0]  sb_set_rd;
  logic [ADD_WIDTH-1:0]  chk_rs1;
  logic [ADD_WIDTH-1:0]  chk_rs2;
  logic                  hazard;
  logic [NREG-1:0]       busy;
  logic                  regwrite;
  logic [ADD_WIDTH-1:0]  add_rd;
  logic [DATA_WIDTH-1:0] write_data;

  int checks = 0;
  int errors = 0;
  wb_req_t exp_q[$];

  regfile_wb_if #(.ADD_WIDTH(ADD_WIDTH), .DATA_WIDTH(DATA_WIDTH)) wb0_if ();
  regfile_wb_if #(.ADD_WIDTH(ADD_WIDTH), .DATA_WIDTH(DATA_WIDTH)) wb1_if ();

  regfile_wb_arbiter #(
    .ADD_WIDTH  (ADD_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb0        (wb0_if),
    .wb1        (wb1_if),
    .sb_set     (sb_set),
    .sb_set_rd  (sb_set_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .hazard     (hazard),
    .busy       (busy),
    .regwrite   (regwrite),
    .add_rd     (add_rd),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic push(logic [ADD_WIDTH-1:0] rd, logic [DATA_WIDTH-1:0] d);
    wb_req_t e;
    e.valid = 1'b1;
    e.rd    = rd;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // every committed write must match the oldest expected write
  always @(negedge clk) begin
    if (regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {32'd0, 27'd0, add_rd}, 64'hdead);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("sb_rd", 64'(add_rd), 64'(e.rd));
        chk("sb_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    sb_set = 1'b0;
    sb_set_rd = '0;
    chk_rs1 = '0;
    chk_rs2 = '0;
    wb0_if.valid = 1'b0;
    wb0_if.rd = '0;
    wb0_if.data = '0;
    wb1_if.valid = 1'b0;
    wb1_if.rd = '0;
    wb1_if.data = '0;
    cyc();
    cyc();
    rst = 1'b0;
    smp();
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_add_rd", 64'(add_rd), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy0", 64'(wb0_if.ready), 64'd0);
    chk("rst_rdy1", 64'(wb1_if.ready), 64'd0);

    // single ALU write
    cyc();
    wb0_if.valid = 1'b1;
    wb0_if.rd = 5'd5;
    wb0_if.data = 32'h34;
    smp();
    chk("t1_rdy0", 64'(wb0_if.ready), 64'd1);
    chk("t1_rdy1", 64'(wb1_if.ready), 64'd0);
    push(5'd5, 32'h34);
    cyc();
    wb0_if.valid = 1'b0;
    smp();
    chk("t1_regwrite", 64'(regwrite), 64'd1);
    chk("t1_add_rd", 64'(add_rd), 64'd5);
    chk("t1_wdata", 64'(write_data), 64'h34);

    // contention, wb0 wins first
    cyc();
    wb0_if.valid = 1'b1;
    wb0_if.rd = 5'd6;
    wb0_if.data = 32'h2;
    wb1_if.valid = 1'b1;
    wb1_if.rd = 5'd7;
    wb1_if.data = 32'h1;
    smp();
    chk("t2_rdy0_c1", 64'(wb0_if.ready), 64'd1);
    chk("t2_rdy1_c1", 64'(wb1_if.ready), 64'd0);
    chk("t2_hold_c1", 64'(add_rd), 64'd5);
    push(5'd6, 32'h2);
    cyc();
    wb0_if.valid = 1'b0;
    smp();
    chk("t2_rdy1_c2", 64'(wb1_if.ready), 64'd1);
    chk("t2_rdy0_c2", 64'(wb0_if.ready), 64'd0);
    chk("t2_add_rd_c2", 64'(add_rd), 64'd6);
    push(5'd7, 32'h1);
    cyc();
    wb1_if.valid = 1'b0;
    smp();
    chk("t2_regwrite_c3", 64'(regwrite), 64'd1);
    chk("t2_add_rd_c3", 64'(add_rd), 64'd7);
    cyc();
    smp();
    chk("t2_idle", 64'(regwrite), 64'd0);
    chk("t2_hold_rd", 64'(add_rd), 64'd7);

    // scoreboard set, hazard, clear on commit
    cyc();
    sb_set = 1'b1;
    sb_set_rd = 5'd9;
    smp();
    chk("t3_haz_c0", 64'(hazard), 64'd0);
    cyc();
    sb_set = 1'b0;
    chk_rs1 = 5'd9;
    smp();
    chk("t3_haz_c1", 64'(hazard), 64'd1);
    chk("t3_busy_c1", 64'(busy), 64'(32'h200));
    cyc();
    wb1_if.valid = 1'b1;
    wb1_if.rd = 5'd9;
    wb1_if.data = 32'h99;
    smp();
    chk("t3_rdy1_c2", 64'(wb1_if.ready), 64'd1);
    chk("t3_haz_c2", 64'(hazard), 64'd1);
    push(5'd9, 32'h99);
    cyc();
    wb1_if.valid = 1'b0;
    smp();
    chk("t3_regwrite_c3", 64'(regwrite), 64'd1);
    chk("t3_haz_c3", 64'(hazard), 64'd1);
    cyc();
    smp();
    chk("t3_haz_c4", 64'(hazard), 64'd0);
    chk("t3_busy_c4", 64'(busy), 64'd0);

    // x0 write and x0 set
    cyc();
    wb0_if.valid = 1'b1;
    wb0_if.rd = 5'd0;
    wb0_if.data = 32'hFFFFFFFF;
    sb_set = 1'b1;
    sb_set_rd = 5'd0;
    smp();
    chk("t4_rdy0", 64'(wb0_if.ready), 64'd1);
    cyc();
    wb0_if.valid = 1'b0;
    sb_set = 1'b0;
    smp();
    chk("t4_regwrite", 64'(regwrite), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);

    // same-cycle set and clear of r11
    cyc();
    wb0_if.valid = 1'b1;
    wb0_if.rd = 5'd11;
    wb0_if.data = 32'hB;
    smp();
    push(5'd11, 32'hB);
    cyc();
    wb0_if.valid = 1'b0;
    sb_set = 1'b1;
    sb_set_rd = 5'd11;
    chk_rs1 = 5'd0;
    chk_rs2 = 5'd11;
    smp();
    chk("t5_regwrite", 64'(regwrite), 64'd1);
    chk("t5_add_rd", 64'(add_rd), 64'd11);
    cyc();
    sb_set = 1'b0;
    smp();
    chk("t5_busy", 64'(busy), 64'(32'h800));
    chk("t5_haz", 64'(hazard), 64'd1);

    // reset after a transfer; rr_last currently favours wb1
    cyc();
    wb1_if.valid = 1'b1;
    wb1_if.rd = 5'd12;
    wb1_if.data = 32'hC;
    smp();
    chk("t6_rdy1", 64'(wb1_if.ready), 64'd1);
    push(5'd12, 32'hC);
    cyc();
    wb1_if.valid = 1'b0;
    rst = 1'b1;
    smp();
    chk("t6_commit", 64'(regwrite), 64'd1);
    cyc();
    rst = 1'b0;
    smp();
    chk("t6_regwrite", 64'(regwrite), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_haz", 64'(hazard), 64'd0);
    cyc();
    wb0_if.valid = 1'b1;
    wb0_if.rd = 5'd13;
    wb0_if.data = 32'hD;
    wb1_if.valid = 1'b1;
    wb1_if.rd = 5'd14;
    wb1_if.data = 32'hE;
    smp();
    chk("t6_rdy0", 64'(wb0_if.ready), 64'd1);
    chk("t6_rdy1_lose", 64'(wb1_if.ready), 64'd0);
    push(5'd13, 32'hD);
    cyc();
    wb0_if.valid = 1'b0;
    smp();
    chk("t6_rdy1", 64'(wb1_if.ready), 64'd1);
    push(5'd14, 32'hE);
    cyc();
    wb1_if.valid = 1'b0;
    smp();
    chk("t6_add_rd", 64'(add_rd), 64'd14);
    chk("t6_wdata", 64'(write_data), 64'hE);
    cyc();
    smp();
    chk("q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
